// File: rtl/rv_mem_arbiter.sv
// Three-way arbiter for one single-port memory: core fetch, core load/store and debug/loader.
// Grants are combinational from the current requests; read data returns one cycle after the grant.
module rv_mem_arbiter #(
  parameter int unsigned AW         = 12,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_wstrb,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic            dbg_lock,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   dbg_rdata,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            locked
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_DBG} owner_e;

  logic          lock_q, lock_d;
  logic          rr_ls_last_q, rr_ls_last_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  owner_e        resp_owner_q, resp_owner_d;

  logic core_req_c, pick_ls_c;
  logic gnt_if_c, gnt_ls_c, gnt_dbg_c;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt_if_c   = 1'b0;
    gnt_ls_c   = 1'b0;
    gnt_dbg_c  = 1'b0;
    core_req_c = if_req | ls_req;
    pick_ls_c  = ls_req & (~if_req | ~rr_ls_last_q);
    if (rst_n) begin
      if (lock_q) begin
        gnt_dbg_c = dbg_req;
      end else if ((starve_cnt_q == CW'(STARVE_MAX)) && core_req_c) begin
        gnt_ls_c = pick_ls_c;
        gnt_if_c = ~pick_ls_c;
      end else if (dbg_req) begin
        gnt_dbg_c = 1'b1;
      end else if (core_req_c) begin
        gnt_ls_c = pick_ls_c;
        gnt_if_c = ~pick_ls_c;
      end
    end
  end

  // Next state for lock, fairness, starvation counter and response owner.
  always_comb begin
    lock_d       = lock_q;
    rr_ls_last_d = rr_ls_last_q;
    starve_cnt_d = starve_cnt_q;
    resp_owner_d = OWN_NONE;

    lock_d = lock_q ? dbg_lock : (gnt_dbg_c & dbg_lock);

    if (gnt_ls_c) rr_ls_last_d = 1'b1;
    if (gnt_if_c) rr_ls_last_d = 1'b0;

    if (gnt_if_c || gnt_ls_c || !core_req_c) begin
      starve_cnt_d = '0;
    end else if (gnt_dbg_c && !lock_q && (starve_cnt_q != CW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end

    if (gnt_if_c)                 resp_owner_d = OWN_IF;
    else if (gnt_ls_c && !ls_we)  resp_owner_d = OWN_LS;
    else if (gnt_dbg_c && !dbg_we) resp_owner_d = OWN_DBG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      rr_ls_last_q <= 1'b0;
      starve_cnt_q <= '0;
      resp_owner_q <= OWN_NONE;
    end else begin
      lock_q       <= lock_d;
      rr_ls_last_q <= rr_ls_last_d;
      starve_cnt_q <= starve_cnt_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Memory port mux from the winner.
  always_comb begin
    mem_ce    = gnt_if_c | gnt_ls_c | gnt_dbg_c;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_if_c) begin
      mem_addr = if_addr;
    end else if (gnt_ls_c) begin
      mem_we    = ls_we;
      mem_wstrb = ls_wstrb;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (gnt_dbg_c) begin
      mem_we    = dbg_we;
      mem_wstrb = {SW{1'b1}};
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign if_gnt     = gnt_if_c;
  assign ls_gnt     = gnt_ls_c;
  assign dbg_gnt    = gnt_dbg_c;
  assign if_rvalid  = (resp_owner_q == OWN_IF);
  assign ls_rvalid  = (resp_owner_q == OWN_LS);
  assign dbg_rvalid = (resp_owner_q == OWN_DBG);
  assign if_rdata   = mem_rdata;
  assign ls_rdata   = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  assign locked     = lock_q;

endmodule
